// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants and types for the instruction fetch stage.
//   MEM_WIDTH_DEF / MEM_SIZE_DEF / RESET_PC_DEF / FIFO_DEPTH_DEF : default
//     configuration of instr_fetch.
//   NOP_WORD      : value presented on instr whenever no instruction is valid.
//   fetch_entry_t : one prefetch buffer entry {instr, pc} at the default widths.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int MEM_WIDTH_DEF  = 32;
    localparam int MEM_SIZE_DEF   = 256;
    localparam int RESET_PC_DEF   = 212;
    localparam int FIFO_DEPTH_DEF = 2;
    localparam int AW_DEF         = $clog2(MEM_SIZE_DEF);

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [MEM_WIDTH_DEF-1:0] instr;
        logic [AW_DEF-1:0]        pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Generic synchronous FIFO used as the fetch prefetch buffer.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
//
// Ports:
//   clk     in   rising-edge clock
//   reset_n in   asynchronous active-low reset (empties the FIFO)
//   push    in   write wdata this cycle (ignored when full without a pop)
//   pop     in   drop the head entry this cycle (ignored when empty)
//   flush   in   discard all entries; overrides push and pop
//   wdata   in   WIDTH-bit entry to write
//   full    out  DEPTH entries held
//   empty   out  no entries held
//   head    out  oldest entry (undefined content when empty)
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] storage [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);

    // A push into a full FIFO is only legal when the head leaves in the same
    // cycle, which keeps the occupancy unchanged.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head = storage[rd_ptr[IW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // NOTE: the data array is deliberately not reset; nothing reads it while
    // the pointers say empty, and the consumer masks head in that case.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            storage[wr_ptr[IW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage in front of the combinational Memory instruction port. It owns
// the word-addressed PC, reads one word per cycle whenever the prefetch FIFO
// can accept it, and hands {instr, pc} to decode over valid/ready.
// A redirect flushes the FIFO and reloads the PC; it has priority over fetch.
//
// Optional feature (macro FETCH_PERF_CNT_EN): adds saturating 32-bit
// performance counters fetch_cnt and stall_cnt.
//
// Ports:
//   clk                 in   rising-edge clock
//   reset_n             in   asynchronous active-low reset
//   mem_addr_instr      out  word address to Memory (the PC register)
//   mem_read_en_instr   out  read enable to Memory (= fetch this cycle)
//   mem_read_val_instr  in   combinational read data for mem_addr_instr
//   redirect_valid      in   taken branch/jump: flush and reload PC
//   redirect_pc         in   redirect target word address
//   instr_valid         out  FIFO head valid
//   instr_ready         in   decode accepts the head this cycle
//   instr               out  head instruction word (0 when not valid)
//   fetch_cnt           out  [FETCH_PERF_CNT_EN] fetches performed
//   stall_cnt           out  [FETCH_PERF_CNT_EN] cycles without a fetch or redirect
//   instr_pc            out  word address of head instruction (0 when not valid)
// -----------------------------------------------------------------------------
module instr_fetch
    import fetch_pkg::*;
#(
    parameter  int MEM_WIDTH  = MEM_WIDTH_DEF,
    parameter  int MEM_SIZE   = MEM_SIZE_DEF,
    parameter  int RESET_PC   = RESET_PC_DEF,
    parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int AW         = $clog2(MEM_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic [AW-1:0]        mem_addr_instr,
    output logic                 mem_read_en_instr,
    input  logic [MEM_WIDTH-1:0] mem_read_val_instr,
    input  logic                 redirect_valid,
    input  logic [AW-1:0]        redirect_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [MEM_WIDTH-1:0] instr,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]          fetch_cnt,
    output logic [31:0]          stall_cnt,
`endif
    output logic [AW-1:0]        instr_pc
);

    // Same layout as fetch_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [MEM_WIDTH-1:0] instr;
        logic [AW-1:0]        pc;
    } entry_t;

    logic [AW-1:0] pc;
    logic [AW-1:0] pc_next;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          fetch;
    entry_t        push_entry;
    entry_t        head_entry;

    // ------------------------------------------------------------------
    // Handshake and fetch decision
    // ------------------------------------------------------------------
    // instr_valid depends only on FIFO state, so decode's ready never loops
    // back into valid.
    assign instr_valid = !fifo_empty;
    assign pop         = instr_valid && instr_ready;

    // Fetching into a full FIFO is fine when the head leaves this cycle.
    // reset_n gates the enable so Memory sees no read while reset is held.
    assign fetch = reset_n && !redirect_valid && (!fifo_full || pop);

    assign mem_addr_instr    = pc;
    assign mem_read_en_instr = fetch;

    // Wrap explicitly so non-power-of-two memory sizes also roll over to 0.
    assign pc_next = (pc == AW'(MEM_SIZE - 1)) ? '0 : pc + AW'(1);

    // ------------------------------------------------------------------
    // PC register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= AW'(RESET_PC);
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (fetch) begin
            pc <= pc_next;
        end
    end

    // ------------------------------------------------------------------
    // Prefetch buffer
    // ------------------------------------------------------------------
    assign push_entry = '{instr: mem_read_val_instr, pc: pc};

    // A redirect flushes; a pop accepted in that same cycle is still a
    // completed handshake from decode's point of view.
    fetch_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fetch),
        .pop     (pop),
        .flush   (redirect_valid),
        .wdata   (push_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head_entry)
    );

    // Head comes straight from FIFO registers: no path from Memory read data.
    assign instr    = fifo_empty ? MEM_WIDTH'(NOP_WORD) : head_entry.instr;
    assign instr_pc = fifo_empty ? '0 : head_entry.pc;

`ifdef FETCH_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters (saturating)
    // ------------------------------------------------------------------
    logic stall;

    // Redirect cycles are excluded: the missing fetch there is intentional.
    assign stall = !redirect_valid && !fetch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (fetch && (fetch_cnt != '1)) fetch_cnt <= fetch_cnt + 32'd1;
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch. A queue-based reference model tracks
// the prefetch contents and PC from the fetch rules; each scenario task also
// checks the concrete values expected for its scenario.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam int MEM_SIZE   = 256;
    localparam int RESET_PC   = 212;
    localparam int FIFO_DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  mem_addr_instr;
    logic        mem_read_en_instr;
    logic [31:0] mem_read_val_instr;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    logic [31:0] imem [MEM_SIZE];
    logic [31:0] s_words [3] = '{32'h0000_1825, 32'h2402_0001, 32'hAC62_0000};

    // Reference model state
    fetch_entry_t q[$];
    int           m_pc;
    logic [31:0]  m_fetch_cnt;
    logic [31:0]  m_stall_cnt;
    logic         e_valid, e_pop, e_fetch;
    logic [49:0]  exp_vec, obs_vec;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign mem_read_val_instr = imem[mem_addr_instr];

    instr_fetch dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .mem_addr_instr     (mem_addr_instr),
        .mem_read_en_instr  (mem_read_en_instr),
        .mem_read_val_instr (mem_read_val_instr),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .instr_valid        (instr_valid),
        .instr_ready        (instr_ready),
        .instr              (instr),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt          (fetch_cnt),
        .stall_cnt          (stall_cnt),
`endif
        .instr_pc           (instr_pc)
    );

    // ---------------------------------------------------------------
    // Model plumbing
    // ---------------------------------------------------------------
    task automatic model_reset();
        q.delete();
        m_pc        = RESET_PC;
        m_fetch_cnt = '0;
        m_stall_cnt = '0;
    endtask

    // Apply inputs just after the falling edge, then derive what the DUT
    // should show this cycle and capture what it does show.
    task automatic drive(input logic rdy, input logic redir, input logic [7:0] rpc);
        instr_ready    = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        e_valid = (q.size() != 0);
        e_pop   = e_valid && rdy;
        e_fetch = !redir && ((q.size() < FIFO_DEPTH) || e_pop);
        exp_vec = {e_valid, e_fetch, 8'(m_pc), 40'h0};
        obs_vec = {instr_valid, mem_read_en_instr, mem_addr_instr, 40'h0};
        if (e_valid) begin
            exp_vec[39:0] = {q[0].instr, q[0].pc};
            obs_vec[39:0] = {instr, instr_pc};
        end
    endtask

    // Advance one clock and update the model with the same edge.
    task automatic step();
        @(posedge clk);
        if (redirect_valid) begin
            q.delete();
            m_pc = int'(redirect_pc);
        end else begin
            if (e_pop) void'(q.pop_front());
            if (e_fetch) begin
                q.push_back('{instr: imem[m_pc], pc: 8'(m_pc)});
                m_pc = (m_pc + 1) % MEM_SIZE;
            end
        end
        if (e_fetch && m_fetch_cnt != 32'hFFFF_FFFF) m_fetch_cnt = m_fetch_cnt + 1;
        if (!redirect_valid && !e_fetch && m_stall_cnt != 32'hFFFF_FFFF)
            m_stall_cnt = m_stall_cnt + 1;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset_n        = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    // ---------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------
    task automatic test_reset();
        #1;
        vectors++;
        if ({instr_valid, mem_read_en_instr, instr, instr_pc} !== 42'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {instr_valid, mem_read_en_instr, instr, instr_pc});
        end
        vectors++;
        if (mem_addr_instr !== 8'(RESET_PC)) begin
            miscompares++;
            $display("FAIL reset_pc: got %0d expected %0d", mem_addr_instr, RESET_PC);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
`ifdef FETCH_PERF_CNT_EN
        vectors++;
        if ({fetch_cnt, stall_cnt} !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_counters: got %h expected 0", {fetch_cnt, stall_cnt});
        end
`endif
    endtask

    task automatic test_stream();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 8'd0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL stream[%0d]: got %h expected %h", i, obs_vec, exp_vec);
            end
            if (i >= 1 && i <= 3) begin
                vectors++;
                if ({instr_valid, instr, instr_pc} !== {1'b1, s_words[i-1], 8'(211 + i)}) begin
                    miscompares++;
                    $display("FAIL stream_head[%0d]: got %h expected %h", i,
                             {instr_valid, instr, instr_pc}, {1'b1, s_words[i-1], 8'(211 + i)});
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 8'd0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got %h expected %h", i, obs_vec, exp_vec);
            end
            if (i >= 2) begin
                vectors++;
                if ({mem_read_en_instr, mem_addr_instr, instr_valid, instr_pc} !==
                    {1'b0, 8'd214, 1'b1, 8'd212}) begin
                    miscompares++;
                    $display("FAIL bp_stall[%0d]: got en=%b addr=%0d valid=%b pc=%0d expected en=0 addr=214 valid=1 pc=212",
                             i, mem_read_en_instr, mem_addr_instr, instr_valid, instr_pc);
                end
            end
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 8'd0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL bp_drain[%0d]: got %h expected %h", i, obs_vec, exp_vec);
            end
            if (i < 3) begin
                vectors++;
                if ({instr_valid, instr, instr_pc} !== {1'b1, s_words[i], 8'(212 + i)}) begin
                    miscompares++;
                    $display("FAIL bp_release[%0d]: got valid=%b pc=%0d expected valid=1 pc=%0d",
                             i, instr_valid, instr_pc, 212 + i);
                end
            end
            step();
        end
    endtask

    task automatic test_redirect();
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 8'd0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL redir_fill[%0d]: got %h expected %h", i, obs_vec, exp_vec);
            end
            step();
        end
        drive(1'b0, 1'b1, 8'd237);
        vectors++;
        if (mem_read_en_instr !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_no_fetch: got %b expected 0", mem_read_en_instr);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 8'd0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL redir_flow[%0d]: got %h expected %h", i, obs_vec, exp_vec);
            end
            vectors++;
            case (i)
                0: if (instr_valid !== 1'b0) begin
                       miscompares++;
                       $display("FAIL redir_bubble: got valid=%b expected 0", instr_valid);
                   end
                1: if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h8C50_0000, 8'd237}) begin
                       miscompares++;
                       $display("FAIL redir_target: got %h expected %h",
                                {instr_valid, instr, instr_pc}, {1'b1, 32'h8C50_0000, 8'd237});
                   end
                default: if ({instr_valid, instr_pc} !== {1'b1, 8'(236 + i)}) begin
                       miscompares++;
                       $display("FAIL redir_follow[%0d]: got valid=%b pc=%0d expected pc=%0d",
                                i, instr_valid, instr_pc, 236 + i);
                   end
            endcase
            step();
        end
    endtask

    task automatic test_wrap();
        logic [31:0] w_words [4] = '{32'h0, 32'h0, 32'h1, 32'h0};
        logic [7:0]  w_pcs   [4] = '{8'd254, 8'd255, 8'd0, 8'd1};
        drive(1'b1, 1'b1, 8'd254);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 8'd0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL wrap[%0d]: got %h expected %h", i, obs_vec, exp_vec);
            end
            if (i >= 1) begin
                vectors++;
                if ({instr_valid, instr, instr_pc} !== {1'b1, w_words[i-1], w_pcs[i-1]}) begin
                    miscompares++;
                    $display("FAIL wrap_head[%0d]: got %h expected %h", i,
                             {instr_valid, instr, instr_pc}, {1'b1, w_words[i-1], w_pcs[i-1]});
                end
            end
            step();
        end
    endtask

    task automatic test_redirect_pop();
        logic [7:0] tgt;
        tgt = 8'($urandom_range(10, 200));
        drive(1'b0, 1'b1, 8'd220);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 8'd0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL rp_fill[%0d]: got %h expected %h", i, obs_vec, exp_vec);
            end
            step();
        end
        drive(1'b1, 1'b1, tgt);
        vectors++;
        if ({instr_valid, instr_pc} !== {1'b1, 8'd220}) begin
            miscompares++;
            $display("FAIL rp_accept: got valid=%b pc=%0d expected valid=1 pc=220",
                     instr_valid, instr_pc);
        end
        step();
        drive(1'b1, 1'b0, 8'd0);
        vectors++;
        if (instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rp_flushed: got valid=%b pc=%0d expected valid=0", instr_valid, instr_pc);
        end
        step();
        drive(1'b1, 1'b0, 8'd0);
        vectors++;
        if ({instr_valid, instr_pc} !== {1'b1, tgt}) begin
            miscompares++;
            $display("FAIL rp_target: got valid=%b pc=%0d expected valid=1 pc=%0d",
                     instr_valid, instr_pc, tgt);
        end
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                  8'($urandom_range(0, MEM_SIZE - 1)));
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h expected %h", i, obs_vec, exp_vec);
            end
            step();
        end
`ifdef FETCH_PERF_CNT_EN
        vectors++;
        if ({fetch_cnt, stall_cnt} !== {m_fetch_cnt, m_stall_cnt}) begin
            miscompares++;
            $display("FAIL perf_counters: got fetch=%0d stall=%0d expected fetch=%0d stall=%0d",
                     fetch_cnt, stall_cnt, m_fetch_cnt, m_stall_cnt);
        end
`endif
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 8'd0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL ar_pre[%0d]: got %h expected %h", i, obs_vec, exp_vec);
            end
            step();
        end
        // Assert reset between clock edges while a stream is flowing.
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({instr_valid, mem_read_en_instr, instr, instr_pc} !== 42'h0) begin
            miscompares++;
            $display("FAIL ar_drop: got %h expected 0",
                     {instr_valid, mem_read_en_instr, instr, instr_pc});
        end
`ifdef FETCH_PERF_CNT_EN
        vectors++;
        if ({fetch_cnt, stall_cnt} !== 64'h0) begin
            miscompares++;
            $display("FAIL ar_counters: got %h expected 0", {fetch_cnt, stall_cnt});
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'd0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL ar_post[%0d]: got %h expected %h", i, obs_vec, exp_vec);
            end
            if (i == 1) begin
                vectors++;
                if ({instr_valid, instr, instr_pc} !== {1'b1, s_words[0], 8'd212}) begin
                    miscompares++;
                    $display("FAIL ar_restart: got %h expected %h",
                             {instr_valid, instr, instr_pc}, {1'b1, s_words[0], 8'd212});
                end
            end
            step();
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        for (int i = 0; i < MEM_SIZE; i++) imem[i] = $urandom;
        imem[212] = 32'h0000_1825;
        imem[213] = 32'h2402_0001;
        imem[214] = 32'hAC62_0000;
        imem[237] = 32'h8C50_0000;
        imem[238] = 32'h2402_0001;
        imem[254] = 32'h0000_0000;
        imem[255] = 32'h0000_0000;
        imem[0]   = 32'h0000_0001;
        imem[1]   = 32'h0000_0000;
        model_reset();
        @(negedge clk);

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_redirect_pop();
        test_random();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
